game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Top-level game controller for the DE2-115 reaction game. It holds the selected difficulty and sequences the game through idle, countdown, timed play and game-over phases. It gates the RNG/LED datapath through game_active, clears score and LEDs at each new game, and ends play on timeout or when the target score is reached. It sits between the debounced KEY pulses and the rng / leds_switches / score_display blocks.

Parameters:
CLK_HZ, 50000000, clock cycles per one-second tick
COUNTDOWN_SECONDS, 3, pre-game countdown length (1..15)
GAME_SECONDS, 30, play duration (1..127)
TARGET_SCORE, 100, score that ends play as a win (12-bit)

Ports:
clk  input  1  system clock (CLOCK_50)
rst  input  1  synchronous reset, active-low (0 = reset)
start  input  1  one-cycle debounced start/restart pulse
sel_easy  input  1  one-cycle pulse, level select 2'b00
sel_med  input  1  one-cycle pulse, level select 2'b01
sel_hard  input  1  one-cycle pulse, level select 2'b10
score  input  12  current score from leds_switches
level  output  2  latched difficulty to rng
game_active  output  1  high only in PLAY; enables rng/led datapath
game_clear  output  1  one-cycle pulse clearing score/LEDs at game start
countdown  output  4  seconds remaining in COUNTDOWN, else 0
seconds_left  output  7  seconds remaining in PLAY; 0 in IDLE/OVER
state  output  2  IDLE=00, COUNTDOWN=01, PLAY=10, OVER=11
win  output  1  high in OVER if target reached, else 0

Behaviour:
- All outputs registered. Reset (rst==0 at clk edge): state=IDLE, level=00, game_active=0, game_clear=0, countdown=0, seconds_left=0, win=0, tick counter=0. Reset mid-game aborts to IDLE immediately.
- Tick counter: counts 0..CLK_HZ-1; tick asserted on the cycle it equals CLK_HZ-1, then wraps to 0. Forced to 0 on every state transition, so the first tick after entry occurs exactly CLK_HZ cycles later.
- Level latch: select pulses are accepted only in IDLE and OVER. Priority when several are asserted together: easy > med > hard. Level holds its value otherwise and is never auto-reverted.
- IDLE: on start -> COUNTDOWN. A select in the same cycle as start is applied, and the new level is used for the game.
- Entry to COUNTDOWN (from IDLE or OVER): countdown=COUNTDOWN_SECONDS, win=0, game_clear=1 for exactly the first cycle in COUNTDOWN.
- COUNTDOWN: each tick decrements countdown. A tick with countdown==1 -> PLAY, with countdown=0, seconds_left=GAME_SECONDS, game_active=1. start is ignored.
- PLAY: each tick decrements seconds_left. Registered score>=TARGET_SCORE -> OVER with win=1, seconds_left frozen at its current value (not cleared). Else tick with seconds_left==1 -> OVER, seconds_left=0, win=0. If both occur in the same cycle, win takes priority (win=1, seconds_left=1 frozen). start is ignored.
- Leaving PLAY: game_active=0 in the first OVER cycle.
- OVER: holds win and seconds_left. On start -> COUNTDOWN via the entry rules above; seconds_left cleared to 0 on entry.
- Widths: counters saturate-free by construction; seconds_left never underflows below 0.
- level changes only in IDLE/OVER, so rng never sees a level change mid-game.

Test Plan:
(All scenarios use CLK_HZ=10, COUNTDOWN_SECONDS=3, GAME_SECONDS=5, TARGET_SCORE=20.)
- Reset then idle 100 cycles -> state=00, level=00, game_active=0, all counters 0; sel_hard pulse -> level=10 next cycle and holds.
- start in IDLE -> next cycle state=01, countdown=3, game_clear=1 for 1 cycle only; countdown 2 at +10 cycles, 1 at +20; state=10, seconds_left=5, game_active=1 at +30.
- PLAY with score=0 -> seconds_left 4,3,2,1 every 10 cycles; at +50 cycles from PLAY entry state=11, seconds_left=0, win=0, game_active=0.
- PLAY, drive score=20 when seconds_left=3 -> next cycle state=11, win=1, seconds_left=3. Then start -> state=01, win=0, seconds_left=0, game_clear pulse.
- sel_med and start pulses during COUNTDOWN/PLAY -> level and state unchanged. sel_easy+sel_hard together in OVER -> level=00.
- rst=0 mid-PLAY -> next cycle state=00, game_active=0, level=00, seconds_left=0.

Source files
------------

// File: rtl/game_sequencer.sv
// Reaction-game controller: latches difficulty and sequences IDLE -> COUNTDOWN -> PLAY -> OVER,
// gating the rng/LED datapath and pulsing game_clear at the start of each game.
module game_sequencer #(
   parameter int CLK_HZ            = 50000000,
   parameter int COUNTDOWN_SECONDS = 3,
   parameter int GAME_SECONDS      = 30,
   parameter int TARGET_SCORE      = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        sel_easy,
   input  logic        sel_med,
   input  logic        sel_hard,
   input  logic [11:0] score,
   output logic [1:0]  level,
   output logic        game_active,
   output logic        game_clear,
   output logic [3:0]  countdown,
   output logic [6:0]  seconds_left,
   output logic [1:0]  state,
   output logic        win
);

   localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);
   localparam logic [3:0]    CD_INIT  = 4'(COUNTDOWN_SECONDS);
   localparam logic [6:0]    GS_INIT  = 7'(GAME_SECONDS);
   localparam logic [11:0]   TARGET   = 12'(TARGET_SCORE);

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_COUNTDOWN = 2'b01,
      S_PLAY      = 2'b10,
      S_OVER      = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [1:0]    level_q, level_d;
   logic          active_q, active_d;
   logic          clear_q, clear_d;
   logic [3:0]    cd_q, cd_d;
   logic [6:0]    sl_q, sl_d;
   logic          win_q, win_d;
   logic          tick;

   assign tick = (tick_q == TICK_MAX);

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      active_d = active_q;
      clear_d  = 1'b0;
      cd_d     = cd_q;
      sl_d     = sl_q;
      win_d    = win_q;
      tick_d   = tick ? '0 : tick_q + 1'b1;

      if (state_q == S_IDLE || state_q == S_OVER) begin
         if (sel_easy)      level_d = 2'b00;
         else if (sel_med)  level_d = 2'b01;
         else if (sel_hard) level_d = 2'b10;
      end

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_d  = S_COUNTDOWN;
               tick_d   = '0;
               cd_d     = CD_INIT;
               sl_d     = '0;
               win_d    = 1'b0;
               active_d = 1'b0;
               clear_d  = 1'b1;
            end
         end
         S_COUNTDOWN: begin
            if (tick) begin
               if (cd_q == 4'd1) begin
                  state_d  = S_PLAY;
                  tick_d   = '0;
                  cd_d     = '0;
                  sl_d     = GS_INIT;
                  active_d = 1'b1;
               end else begin
                  cd_d = cd_q - 4'd1;
               end
            end
         end
         S_PLAY: begin
            // A win on the final tick keeps seconds_left frozen rather than clearing it
            if (score >= TARGET) begin
               state_d  = S_OVER;
               tick_d   = '0;
               win_d    = 1'b1;
               active_d = 1'b0;
            end else if (tick) begin
               if (sl_q == 7'd1) begin
                  state_d  = S_OVER;
                  tick_d   = '0;
                  sl_d     = '0;
                  win_d    = 1'b0;
                  active_d = 1'b0;
               end else begin
                  sl_d = sl_q - 7'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         level_q  <= 2'b00;
         active_q <= 1'b0;
         clear_q  <= 1'b0;
         cd_q     <= '0;
         sl_q     <= '0;
         win_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         level_q  <= level_d;
         active_q <= active_d;
         clear_q  <= clear_d;
         cd_q     <= cd_d;
         sl_q     <= sl_d;
         win_q    <= win_d;
      end
   end

   assign state        = state_q;
   assign level        = level_q;
   assign game_active  = active_q;
   assign game_clear   = clear_q;
   assign countdown    = cd_q;
   assign seconds_left = sl_q;
   assign win          = win_q;

endmodule
